// File: rtl/wide_sync_stabilizer.sv
// Publishes a synchronized bus only after it holds steady for STABLE_CYCLES enabled cycles.
// Optional glitch counter enabled by WIDE_SYNC_STABILIZER_GLITCH_COUNT_EN.
module wide_sync_stabilizer #(
    parameter int WIDTH         = 8,
    parameter int STABLE_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [WIDTH-1:0] in,
`ifdef WIDE_SYNC_STABILIZER_GLITCH_COUNT_EN
    output logic [15:0]      glitch_count,
`endif
    output logic [WIDTH-1:0] out,
    output logic             update
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);

    typedef enum logic {
        IDLE,
        SETTLING
    } state_t;

    state_t           state;
    state_t           state_n;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_n;
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] prev_n;
    logic [WIDTH-1:0] out_n;
    logic             update_n;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            cnt    <= '0;
            prev   <= '0;
            out    <= '0;
            update <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            prev   <= prev_n;
            out    <= out_n;
            update <= update_n;
        end
    end

    // A change on the completing edge restarts: in != prev wins.
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        prev_n   = prev;
        out_n    = out;
        update_n = 1'b0;
        if (enable) begin
            prev_n = in;
            unique case (state)
                IDLE: begin
                    if (in != out) begin
                        state_n = SETTLING;
                        cnt_n   = '0;
                    end
                end
                SETTLING: begin
                    if (in != prev) begin
                        cnt_n = '0;
                    end else if (cnt == LAST) begin
                        state_n = IDLE;
                        cnt_n   = '0;
                        if (in != out) begin
                            out_n    = in;
                            update_n = 1'b1;
                        end
                    end else begin
                        cnt_n = cnt + CW'(1);
                    end
                end
                default: begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end
            endcase
        end
    end

`ifdef WIDE_SYNC_STABILIZER_GLITCH_COUNT_EN
    logic glitch;

    // Aborted attempt: restart, or a run that settles back on the published value.
    always_comb begin
        glitch = 1'b0;
        if (enable && state == SETTLING) begin
            if (in != prev) begin
                glitch = 1'b1;
            end else if (cnt == LAST && in == out) begin
                glitch = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            glitch_count <= '0;
        end else if (glitch && glitch_count != 16'hFFFF) begin
            glitch_count <= glitch_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_wide_sync_stabilizer.sv
// Directed vector bench for wide_sync_stabilizer (WIDTH=8, STABLE_CYCLES=2).
module tb_wide_sync_stabilizer;

    typedef struct {
        logic        en;
        logic [7:0]  din;
        logic [7:0]  dout;
        logic        upd;
        logic [15:0] gc;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        enable;
    logic [7:0]  in;
    logic [7:0]  out;
    logic        update;
    logic [15:0] gcv;

    int total;
    int passed;

    vec_t vq[$];

`ifdef WIDE_SYNC_STABILIZER_GLITCH_COUNT_EN
    logic [15:0] glitch_count;
    assign gcv = glitch_count;
`else
    assign gcv = 16'd0;
`endif

    wide_sync_stabilizer #(
        .WIDTH(8),
        .STABLE_CYCLES(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .enable(enable),
        .in(in),
`ifdef WIDE_SYNC_STABILIZER_GLITCH_COUNT_EN
        .glitch_count(glitch_count),
`endif
        .out(out),
        .update(update)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total = total + 1;
        if (act === exp) begin
            passed = passed + 1;
        end else begin
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input logic [7:0] eo, input logic eu,
                           input logic [15:0] eg);
        chk({tag, ".out"}, 32'(out), 32'(eo));
        chk({tag, ".update"}, 32'(update), 32'(eu));
`ifdef WIDE_SYNC_STABILIZER_GLITCH_COUNT_EN
        chk({tag, ".glitch"}, 32'(gcv), 32'(eg));
`else
        if (eg != gcv && 1'b0) $display("unused");
`endif
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic e, input logic [7:0] d, input logic [7:0] o,
                                input logic u, input logic [15:0] g);
        vec_t v;
        v.en = e;
        v.din = d;
        v.dout = o;
        v.upd = u;
        v.gc = g;
        return v;
    endfunction

    initial begin
        total = 0;
        passed = 0;
        rst = 1'b0;
        enable = 1'b1;
        in = 8'hA5;

        // A5 -> 00
        vq.push_back(mk(1, 8'h00, 8'hA5, 0, 0));
        vq.push_back(mk(1, 8'h00, 8'hA5, 0, 0));
        vq.push_back(mk(1, 8'h00, 8'h00, 1, 0));
        vq.push_back(mk(1, 8'h00, 8'h00, 0, 0));
        // clean 00 -> 3C
        vq.push_back(mk(1, 8'h3C, 8'h00, 0, 0));
        vq.push_back(mk(1, 8'h3C, 8'h00, 0, 0));
        vq.push_back(mk(1, 8'h3C, 8'h3C, 1, 0));
        vq.push_back(mk(1, 8'h3C, 8'h3C, 0, 0));
        vq.push_back(mk(1, 8'h3C, 8'h3C, 0, 0));
        // skewed bits
        vq.push_back(mk(1, 8'h0F, 8'h3C, 0, 0));
        vq.push_back(mk(1, 8'h3F, 8'h3C, 0, 1));
        vq.push_back(mk(1, 8'hFF, 8'h3C, 0, 2));
        vq.push_back(mk(1, 8'hFF, 8'h3C, 0, 2));
        vq.push_back(mk(1, 8'hFF, 8'hFF, 1, 2));
        vq.push_back(mk(1, 8'hFF, 8'hFF, 0, 2));
        // publish 11
        vq.push_back(mk(1, 8'h11, 8'hFF, 0, 2));
        vq.push_back(mk(1, 8'h11, 8'hFF, 0, 2));
        vq.push_back(mk(1, 8'h11, 8'h11, 1, 2));
        // bounce back
        vq.push_back(mk(1, 8'h12, 8'h11, 0, 2));
        vq.push_back(mk(1, 8'h11, 8'h11, 0, 3));
        vq.push_back(mk(1, 8'h11, 8'h11, 0, 3));
        vq.push_back(mk(1, 8'h11, 8'h11, 0, 4));
        vq.push_back(mk(1, 8'h11, 8'h11, 0, 4));
        vq.push_back(mk(1, 8'h11, 8'h11, 0, 4));
        // enable gating mid-settle
        vq.push_back(mk(1, 8'h55, 8'h11, 0, 4));
        vq.push_back(mk(0, 8'h55, 8'h11, 0, 4));
        vq.push_back(mk(0, 8'h55, 8'h11, 0, 4));
        vq.push_back(mk(0, 8'h55, 8'h11, 0, 4));
        vq.push_back(mk(1, 8'h55, 8'h11, 0, 4));
        vq.push_back(mk(1, 8'h55, 8'h55, 1, 4));
        vq.push_back(mk(1, 8'h55, 8'h55, 0, 4));
        // disabled edge clears a pending update
        vq.push_back(mk(1, 8'h66, 8'h55, 0, 4));
        vq.push_back(mk(1, 8'h66, 8'h55, 0, 4));
        vq.push_back(mk(1, 8'h66, 8'h66, 1, 4));
        vq.push_back(mk(0, 8'h66, 8'h66, 0, 4));
        vq.push_back(mk(1, 8'h66, 8'h66, 0, 4));
        // change on the completing edge restarts
        vq.push_back(mk(1, 8'h77, 8'h66, 0, 4));
        vq.push_back(mk(1, 8'h77, 8'h66, 0, 4));
        vq.push_back(mk(1, 8'h78, 8'h66, 0, 5));
        vq.push_back(mk(1, 8'h78, 8'h66, 0, 5));
        vq.push_back(mk(1, 8'h78, 8'h78, 1, 5));
        vq.push_back(mk(1, 8'h78, 8'h78, 0, 5));

        // reset held with A5 on the bus
        step();
        step();
        chk_all("reset", 8'h00, 1'b0, 16'd0);
        rst = 1'b1;
        step();
        chk_all("rel1", 8'h00, 1'b0, 16'd0);
        step();
        chk_all("rel2", 8'h00, 1'b0, 16'd0);
        step();
        chk_all("rel3", 8'hA5, 1'b1, 16'd0);
        for (int i = 0; i < 2; i++) begin
            step();
            chk_all("rel_hold", 8'hA5, 1'b0, 16'd0);
        end

        foreach (vq[i]) begin
            enable = vq[i].en;
            in = vq[i].din;
            step();
            chk_all($sformatf("vec%0d", i), vq[i].dout, vq[i].upd, vq[i].gc);
        end

        // reset mid-settle
        enable = 1'b1;
        in = 8'h99;
        step();
        chk_all("pre_rst", 8'h78, 1'b0, 16'd5);
        #2;
        rst = 1'b0;
        #1;
        chk_all("async_rst", 8'h00, 1'b0, 16'd0);
        step();
        rst = 1'b1;
        step();
        chk_all("post1", 8'h00, 1'b0, 16'd0);
        step();
        chk_all("post2", 8'h00, 1'b0, 16'd0);
        step();
        chk_all("post3", 8'h99, 1'b1, 16'd0);
        step();
        chk_all("post4", 8'h99, 1'b0, 16'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
